// File: rtl/rr_arb_mux4.sv
// rr_arb_mux4: four-input round-robin arbitrating multiplexer with a
// registered output stage.
//
// Each cycle one valid input is picked, starting the search at the round-robin
// pointer. The chosen word is registered on `out`, and its source index is
// registered on `sel`. The output stage behaves as a one-entry buffer. It
// reloads whenever it is empty or being drained, so it runs back-to-back
// without a bubble.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in0..in3   candidate data words (WIDTH bits each)
//   in_valid   per-input valid, bit i qualifies in<i>
//   in_ready   per-input accept, at most one bit set (combinational)
//   out        registered selected word
//   sel        registered source index of out
//   out_valid  out/sel hold a word
//   out_ready  downstream consumes out this cycle
//
// Output stage states
//   state    | meaning
//   ST_EMPTY | no word held, out_valid=0, always able to load
//   ST_FULL  | word held on out/sel, out_valid=1, loads only when out_ready

module rr_arb_mux4 #(
    parameter int WIDTH    = 8,
    parameter int SEL_BITS = 2   // must be 2 for four inputs
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    in0,
    input  logic [WIDTH-1:0]    in1,
    input  logic [WIDTH-1:0]    in2,
    input  logic [WIDTH-1:0]    in3,
    input  logic [3:0]          in_valid,
    output logic [3:0]          in_ready,
    output logic [WIDTH-1:0]    out,
    output logic [SEL_BITS-1:0] sel,
    output logic                out_valid,
    input  logic                out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic [SEL_BITS-1:0] sel_q, sel_d;
    logic [1:0]          ptr_q, ptr_d;

    logic                load;
    logic                any_valid;
    logic                grant;
    logic [1:0]          winner;
    logic [1:0]          cand;
    logic [WIDTH-1:0]    win_data;

    // Round-robin search: offsets are walked from farthest to nearest, so
    // the nearest valid index at or after ptr_q is the last one written.
    always_comb begin
        winner    = ptr_q;
        cand      = '0;
        any_valid = |in_valid;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (in_valid[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        win_data = in0;
        case (winner)
            2'd0:    win_data = in0;
            2'd1:    win_data = in1;
            2'd2:    win_data = in2;
            default: win_data = in3;
        endcase
    end

    assign load = (state_q == ST_EMPTY) || out_ready;

    // Mask the grant while reset is high. This keeps in_ready quiet even
    // though the empty stage would otherwise offer a load.
    assign grant    = load && any_valid && !rst;
    assign in_ready = grant ? (4'b0001 << winner) : 4'b0000;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_EMPTY: begin
                if (any_valid) begin
                    state_d = ST_FULL;
                    out_d   = win_data;
                    sel_d   = SEL_BITS'(winner);
                    ptr_d   = winner + 2'd1;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (any_valid) begin
                        // Drain and refill in the same cycle.
                        out_d = win_data;
                        sel_d = SEL_BITS'(winner);
                        ptr_d = winner + 2'd1;
                    end else begin
                        // Drain only: data and pointer are left as they were.
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out       = out_q;
    assign sel       = sel_q;
    assign out_valid = (state_q == ST_FULL);

endmodule
